// File: rtl/display_pkg.sv
// Shared types, FSM encodings and helpers for the display scheduler.
package display_pkg;

    localparam int unsigned DATA_W = 16;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHOW = 2'd1;
    localparam logic [1:0] PICK = 2'd2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/display_scheduler_rr_pick.sv
// Combinational next-source finder: lowest set index, or round-robin after cur.
module rr_pick #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned SRC_W = 2
) (
    input  logic [N_SRC-1:0] mask,
    input  logic [SRC_W-1:0] cur,
    input  logic             wrap,
    output logic [SRC_W-1:0] next_idx,
    output logic             found
);

    int idx;

    // Walk candidates from last to first so the earliest match in search order wins.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = int'(N_SRC); k >= 1; k--) begin
            idx = wrap ? ((int'(cur) + k) % int'(N_SRC)) : (k - 1);
            if (mask[SRC_W'(idx)]) begin
                next_idx = SRC_W'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin sharing of the 4-digit hex display between N_SRC word sources,
// switching the displayed word only just after the vsync falling edge.
module display_scheduler
    import display_pkg::*;
#(
    parameter int unsigned N_SRC           = 4,
    parameter int unsigned FRAMES_PER_SLOT = 60,
    parameter int unsigned SRC_W           = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vga_v_sync,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [DATA_W*N_SRC-1:0]   src_data,
    output logic [N_SRC-1:0]          src_ready,
    output logic [DATA_W-1:0]         num,
    output logic [SRC_W-1:0]          num_src,
    output logic                      num_live
);

    localparam int unsigned FC_W = (clog2(FRAMES_PER_SLOT) > 0) ? clog2(FRAMES_PER_SLOT) : 1;
    localparam logic [FC_W-1:0] LAST = FC_W'(FRAMES_PER_SLOT - 1);

    logic              s1, s2, s3, tick;
    logic [1:0]        state, state_nxt;
    logic [SRC_W-1:0]  target, target_nxt;
    logic              expire, expire_nxt;
    logic [FC_W-1:0]   frame_cnt;
    logic [N_SRC-1:0]  pend, pend_nxt, has_data, accept_c;
    word_t             slot_data [N_SRC];
    logic [SRC_W-1:0]  pick_idx;
    logic              pick_found, wrap_c;

    assign accept_c = src_valid & src_ready;
    assign wrap_c   = (state != IDLE);

    rr_pick #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_rr_pick (
        .mask     (has_data),
        .cur      (num_src),
        .wrap     (wrap_c),
        .next_idx (pick_idx),
        .found    (pick_found)
    );

    // vsync synchroniser; tick is a registered one-cycle falling-edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            s3   <= 1'b1;
            tick <= 1'b0;
        end else begin
            s1   <= vga_v_sync;
            s2   <= s1;
            s3   <= s2;
            tick <= s3 & ~s2;
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        expire_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (tick && pick_found) begin
                    state_nxt  = PICK;
                    target_nxt = pick_idx;
                end
            end
            SHOW: begin
                if (tick) begin
                    if (frame_cnt == LAST) begin
                        state_nxt  = PICK;
                        target_nxt = pick_found ? pick_idx : num_src;
                        expire_nxt = 1'b1;
                    end else if (pend[num_src]) begin
                        state_nxt  = PICK;
                        target_nxt = num_src;
                    end
                end
            end
            PICK:    state_nxt = SHOW;
            default: state_nxt = IDLE;
        endcase
    end

    // A same-cycle accept overrides the PICK clear, so a colliding write stays pending.
    always_comb begin
        pend_nxt = pend;
        if (state == PICK) pend_nxt[target] = 1'b0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (accept_c[i]) pend_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            target    <= '0;
            expire    <= 1'b0;
            frame_cnt <= '0;
            pend      <= '0;
            has_data  <= '0;
            src_ready <= '0;
            num       <= '0;
            num_src   <= '0;
            num_live  <= 1'b0;
            for (int i = 0; i < int'(N_SRC); i++) slot_data[i] <= '0;
        end else begin
            state     <= state_nxt;
            target    <= target_nxt;
            expire    <= expire_nxt;
            pend      <= pend_nxt;
            src_ready <= ~pend_nxt;
            if (state == PICK && expire) begin
                frame_cnt <= '0;
            end else if (state == SHOW && tick && frame_cnt != LAST) begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
            if (state == PICK) begin
                num      <= slot_data[target];
                num_src  <= target;
                num_live <= 1'b1;
            end
            for (int i = 0; i < int'(N_SRC); i++) begin
                if (accept_c[i]) begin
                    slot_data[i] <= src_data[DATA_W*i +: DATA_W];
                    has_data[i]  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench: dut_a (2 frames/slot) for reset, single source, rotation,
// collision and mid-run reset; dut_b (60 frames/slot) for refresh within a dwell.
module tb_display_scheduler;

    logic        clk, rst, vga_v_sync;
    logic [3:0]  a_valid, a_ready, b_valid, b_ready;
    logic [63:0] a_data, b_data;
    logic [15:0] a_num, b_num;
    logic [1:0]  a_src, b_src;
    logic        a_live, b_live;

    int total, bad;
    logic [15:0] exp_num [7];
    logic [1:0]  exp_src [7];
    logic [15:0] prev;

    display_scheduler #(.N_SRC(4), .FRAMES_PER_SLOT(2), .SRC_W(2)) dut_a (
        .clk(clk), .rst(rst), .vga_v_sync(vga_v_sync),
        .src_valid(a_valid), .src_data(a_data), .src_ready(a_ready),
        .num(a_num), .num_src(a_src), .num_live(a_live)
    );

    display_scheduler #(.N_SRC(4), .FRAMES_PER_SLOT(60), .SRC_W(2)) dut_b (
        .clk(clk), .rst(rst), .vga_v_sync(vga_v_sync),
        .src_valid(b_valid), .src_data(b_data), .src_ready(b_ready),
        .num(b_num), .num_src(b_src), .num_live(b_live)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drop vsync and advance to the PICK cycle (4 edges after the fall).
    task automatic vs_fall();
        vga_v_sync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic vs_finish();
        @(negedge clk);
    endtask

    task automatic vs_rest();
        vga_v_sync = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; vga_v_sync = 1'b1;
        a_valid = '0; a_data = '0; b_valid = '0; b_data = '0;
        exp_num[0] = 16'h1111; exp_num[1] = 16'h1111; exp_num[2] = 16'h2222;
        exp_num[3] = 16'h2222; exp_num[4] = 16'h4444; exp_num[5] = 16'h4444;
        exp_num[6] = 16'h1111;
        exp_src[0] = 2'd0; exp_src[1] = 2'd0; exp_src[2] = 2'd1;
        exp_src[3] = 2'd1; exp_src[4] = 2'd3; exp_src[5] = 2'd3;
        exp_src[6] = 2'd0;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(a_ready), 32'h0);
        check("rst_live", 32'(a_live), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", 32'(a_ready), 32'hF);
        check("rel_num", 32'(a_num), 32'h0);
        check("rel_live", 32'(a_live), 32'h0);
        check("rel_src", 32'(a_src), 32'h0);
        check("rel_ready_b", 32'(b_ready), 32'hF);

        // Single source
        a_data[47:32] = 16'hBEEF;
        a_valid = 4'b0100;
        @(negedge clk);
        a_valid = '0;
        check("post_ready", 32'(a_ready), 32'hB);
        vs_fall();
        check("single_pre_num", 32'(a_num), 32'h0);
        check("single_pre_live", 32'(a_live), 32'h0);
        vs_finish();
        check("single_num", 32'(a_num), 32'hBEEF);
        check("single_src", 32'(a_src), 32'h2);
        check("single_live", 32'(a_live), 32'h1);
        check("single_ready", 32'(a_ready), 32'hF);
        vs_rest();

        // Mid-operation reset
        rst = 1'b1;
        @(negedge clk);
        check("mrst_num", 32'(a_num), 32'h0);
        check("mrst_live", 32'(a_live), 32'h0);
        check("mrst_src", 32'(a_src), 32'h0);
        check("mrst_ready", 32'(a_ready), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_rel_ready", 32'(a_ready), 32'hF);
        vs_fall();
        vs_finish();
        check("mrst_stale_num", 32'(a_num), 32'h0);
        check("mrst_stale_live", 32'(a_live), 32'h0);
        vs_rest();

        // Rotation, 2 frames per slot
        a_data = {16'h4444, 16'h0000, 16'h2222, 16'h1111};
        a_valid = 4'b1011;
        @(negedge clk);
        a_valid = '0;
        check("rot_post_ready", 32'(a_ready), 32'h4);
        prev = 16'h0000;
        for (int f = 0; f < 6; f++) begin
            vs_fall();
            check("rot_hold", 32'(a_num), 32'(prev));
            vs_finish();
            check("rot_num", 32'(a_num), 32'(exp_num[f]));
            check("rot_src", 32'(a_src), 32'(exp_src[f]));
            prev = exp_num[f];
            vs_rest();
        end

        // Wrap to source 0 with a colliding write in the PICK cycle
        vs_fall();
        check("wrap_hold", 32'(a_num), 32'h4444);
        a_data[15:0] = 16'h0F0F;
        a_valid = 4'b0001;
        vs_finish();
        a_valid = '0;
        check("col_num", 32'(a_num), 32'(exp_num[6]));
        check("col_src", 32'(a_src), 32'(exp_src[6]));
        check("col_ready", 32'(a_ready), 32'hE);
        vs_rest();
        vs_fall();
        vs_finish();
        check("col_next_num", 32'(a_num), 32'h0F0F);
        check("col_next_src", 32'(a_src), 32'h0);
        check("col_next_ready", 32'(a_ready), 32'hF);
        vs_rest();
        vs_fall();
        vs_finish();
        check("col_dwell_num", 32'(a_num), 32'h2222);
        check("col_dwell_src", 32'(a_src), 32'h1);
        vs_rest();

        // Refresh inside a 60-frame dwell
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        b_data = {16'h0000, 16'h5678, 16'h1234, 16'h0000};
        b_valid = 4'b0110;
        @(negedge clk);
        b_valid = '0;
        check("ref_post_ready", 32'(b_ready), 32'h9);
        for (int k = 1; k <= 61; k++) begin
            vs_fall();
            vs_finish();
            if (k == 1) begin
                check("ref_first_num", 32'(b_num), 32'h1234);
                check("ref_first_src", 32'(b_src), 32'h1);
                check("ref_first_live", 32'(b_live), 32'h1);
                check("ref_first_ready", 32'(b_ready), 32'hB);
            end
            if (k == 10) check("ref_f10_num", 32'(b_num), 32'h1234);
            if (k == 11) begin
                check("ref_f11_num", 32'(b_num), 32'hA5A5);
                check("ref_f11_src", 32'(b_src), 32'h1);
                check("ref_f11_ready", 32'(b_ready), 32'hB);
            end
            if (k == 60) begin
                check("ref_f60_num", 32'(b_num), 32'hA5A5);
                check("ref_f60_src", 32'(b_src), 32'h1);
            end
            if (k == 61) begin
                check("ref_f61_num", 32'(b_num), 32'h5678);
                check("ref_f61_src", 32'(b_src), 32'h2);
                check("ref_f61_ready", 32'(b_ready), 32'hF);
            end
            vs_rest();
            if (k == 10) begin
                b_data[31:16] = 16'hA5A5;
                b_valid = 4'b0010;
                @(negedge clk);
                b_valid = '0;
                check("ref_post2_ready", 32'(b_ready), 32'h9);
            end
        end
        check("ref_a_idle_live", 32'(a_live), 32'h0);
        check("ref_a_idle_num", 32'(a_num), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
